icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of 2, ≥2).
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 CPU_RDEN  in  1  fetch request; sampled only when CPU_BUSY=0.
REQ-006 CPU_ADDR  in  32  fetch byte address; bits [1:0] ignored.
REQ-007 FLUSH  in  1  single-cycle pulse; invalidates all lines.
REQ-008 CPU_DOUT  out  32  fetched instruction, meaningful only while CPU_VALID=1.
REQ-009 CPU_VALID  out  1  one-cycle pulse marking CPU_DOUT valid.
REQ-010 CPU_BUSY  out  1  cache filling; core holds PC and issues no request.
REQ-011 MEM_RDEN  out  1  read strobe to instruction memory port 1.
REQ-012 MEM_ADDR  out  14  word address to memory port 1 (byte address [15:2]).
REQ-013 MEM_DOUT  in  32  memory read data, valid exactly one cycle after MEM_RDEN.
REQ-014 HIT_CNT, MISS_CNT  out  16 each  saturating performance counters.

Function
REQ-015 Address split: offset=ADDR[log2(WORDS)+1:2], index=next log2(LINES) bits, tag=ADDR[31:log2(LINES*WORDS)+2] (defaults: [3:2], [7:4], [31:8]).
REQ-016 Storage per line: valid bit, tag, WORDS data words; data/tag arrays not reset, valid bits reset.
REQ-017 States: IDLE, FILL, RESP; CPU_BUSY=1 in FILL and RESP, 0 in IDLE.
REQ-018 IDLE, CPU_RDEN=1, hit (valid & tag equal): next cycle CPU_VALID=1, CPU_DOUT=stored word; state stays IDLE; back-to-back hits sustain one per cycle.
REQ-019 IDLE, CPU_RDEN=1, miss: latch address, enter FILL next cycle, fill counter k=0.
REQ-020 FILL: cycles 0..WORDS-1 drive MEM_RDEN=1, MEM_ADDR={latched ADDR[15:offset_msb+1], k}; words fill in ascending order from offset 0 (no critical-word-first).
REQ-021 FILL: MEM_DOUT captured cycle after each strobe into word k of the line; after last word captured (FILL lasts WORDS+1 cycles) set tag, set valid, enter RESP.
REQ-022 RESP: CPU_VALID=1, CPU_DOUT=requested word of filled line; next state IDLE.
REQ-023 Miss latency: request at cycle 0 -> CPU_VALID at cycle WORDS+2 (6 for default).
REQ-024 CPU_RDEN while CPU_BUSY=1 is ignored: no lookup, no counter change.
REQ-025 MEM_RDEN=0 in IDLE and RESP; MEM_ADDR holds last value when MEM_RDEN=0.
REQ-026 CPU_VALID=0 in every cycle not specified by REQ-018/REQ-022.
REQ-027 FLUSH in IDLE: all valid bits cleared at that edge; a same-cycle request is treated as a miss.
REQ-028 FLUSH in FILL/RESP: valid bits cleared; in-progress fill completes and response is delivered, but the filled line is left invalid.
REQ-029 HIT_CNT increments on each accepted hit, MISS_CNT on each accepted miss; both saturate at 0xFFFF.
REQ-030 Conflict miss overwrites the line unconditionally (read-only cache, no write-back).

Reset
REQ-031 RST_N=0 asynchronously forces: state IDLE, all valid bits 0, CPU_VALID=0, CPU_BUSY=0, MEM_RDEN=0, MEM_ADDR=0, CPU_DOUT=0, HIT_CNT=0, MISS_CNT=0.
REQ-032 Reset mid-FILL abandons the fill; partially written line remains invalid; no CPU_VALID follows.
REQ-033 First request after RST_N deasserts is accepted at the first posedge with RST_N=1.

Verification
REQ-034 Cold miss: memory word n holds n; request 0x100 -> MEM_RDEN cycles 1-4 with MEM_ADDR 0x40-0x43, CPU_VALID cycle 6, CPU_DOUT=0x40, MISS_CNT=1.
REQ-035 Hit streak: after REQ-034, requests 0x104, 0x108, 0x10C on consecutive cycles -> CPU_VALID three consecutive cycles, DOUT 0x41, 0x42, 0x43, HIT_CNT=3, MEM_RDEN never asserted.
REQ-036 Conflict: request 0x1100 (same index 0) -> miss, fill 0x440-0x443; then 0x100 -> miss again, DOUT=0x40.
REQ-037 Flush: FLUSH pulse during FILL of 0x200 -> DOUT=0x80 delivered; immediate re-request 0x200 -> miss.
REQ-038 Reset mid-FILL: RST_N low at FILL cycle 2 -> MEM_RDEN, CPU_BUSY, counters 0 immediately; re-request after release -> miss.
REQ-039 Busy gating and saturation: CPU_RDEN held high through a fill causes only one miss count; 65536 hits preload -> HIT_CNT stays 0xFFFF.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a single fill port.
// Lines fill in ascending word order; hits return one cycle after request.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_rden_i,
    input  logic [31:0] cpu_addr_i,
    input  logic        flush_i,
    output logic [31:0] cpu_dout_o,
    output logic        cpu_valid_o,
    output logic        cpu_busy_o,
    output logic        mem_rden_o,
    output logic [13:0] mem_addr_o,
    input  logic [31:0] mem_dout_i,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = OFF_W + IDX_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int CNT_W   = OFF_W + 1;
    localparam int HI_W    = 14 - OFF_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [HI_W-1:0]    memhi_q, memhi_d;
    logic               flushed_q, flushed_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               cpu_valid_q, cpu_valid_d;
    logic [31:0]        cpu_dout_q, cpu_dout_d;
    logic               mem_rden_q, mem_rden_d;
    logic [13:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        hit_q, hit_d, miss_q, miss_d;

    logic [31:0]        data_arr_q [LINES][WORDS];
    logic [TAG_W-1:0]   tag_arr_q  [LINES];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_hit;
    logic               line_we, tag_we;
    logic [OFF_W-1:0]   wr_off;
    logic               unused_addr_lsb;

    assign req_off         = cpu_addr_i[OFF_W+1:2];
    assign req_idx         = cpu_addr_i[TAG_LSB-1:OFF_W+2];
    assign req_tag         = cpu_addr_i[31:TAG_LSB];
    assign req_hit         = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);
    assign wr_off          = OFF_W'(cnt_q - CNT_W'(1));
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign cpu_dout_o  = cpu_dout_q;
    assign cpu_valid_o = cpu_valid_q;
    assign cpu_busy_o  = (state_q != IDLE);
    assign mem_rden_o  = mem_rden_q;
    assign mem_addr_o  = mem_addr_q;
    assign hit_cnt_o   = hit_q;
    assign miss_cnt_o  = miss_q;

    // Next-state and registered-output logic; strobe k+1 is scheduled while word k-1 lands.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        memhi_d     = memhi_q;
        flushed_d   = flushed_q;
        valid_d     = valid_q;
        cpu_valid_d = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        mem_rden_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_rden_i) begin
                    if (req_hit && !flush_i) begin
                        cpu_valid_d = 1'b1;
                        cpu_dout_d  = data_arr_q[req_idx][req_off];
                        if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
                    end else begin
                        off_d      = req_off;
                        idx_d      = req_idx;
                        tag_d      = req_tag;
                        memhi_d    = cpu_addr_i[15:OFF_W+2];
                        flushed_d  = 1'b0;
                        cnt_d      = '0;
                        mem_rden_d = 1'b1;
                        mem_addr_d = {cpu_addr_i[15:OFF_W+2], {OFF_W{1'b0}}};
                        state_d    = FILL;
                        if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
                    end
                end
            end
            FILL: begin
                line_we = (cnt_q != '0);
                cnt_d   = cnt_q + CNT_W'(1);
                if (flush_i) flushed_d = 1'b1;
                if (cnt_q < CNT_W'(WORDS - 1)) begin
                    mem_rden_d = 1'b1;
                    mem_addr_d = {memhi_q, OFF_W'(cnt_q + CNT_W'(1))};
                end
                if (cnt_q == CNT_W'(WORDS)) begin
                    tag_we      = 1'b1;
                    if (!flushed_q) valid_d[idx_q] = 1'b1;
                    cpu_valid_d = 1'b1;
                    cpu_dout_d  = (off_q == OFF_W'(WORDS - 1)) ? mem_dout_i
                                                               : data_arr_q[idx_q][off_q];
                    state_d     = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over any valid bit set this cycle.
        if (flush_i) valid_d = '0;
    end

    // Control state, valid bits, outputs and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            memhi_q     <= '0;
            flushed_q   <= 1'b0;
            valid_q     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_dout_q  <= '0;
            mem_rden_q  <= 1'b0;
            mem_addr_q  <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            memhi_q     <= memhi_d;
            flushed_q   <= flushed_d;
            valid_q     <= valid_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_dout_q  <= cpu_dout_d;
            mem_rden_q  <= mem_rden_d;
            mem_addr_q  <= mem_addr_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    // Tag and data storage; contents are qualified by valid bits, so no reset.
    always_ff @(posedge clk_i) begin
        if (line_we) data_arr_q[idx_q][wr_off] <= mem_dout_i;
        if (tag_we)  tag_arr_q[idx_q]          <= tag_q;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: memory word n holds value n.
module tb_icache_dm;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_rden_i;
    logic [31:0] cpu_addr_i;
    logic        flush_i;
    logic [31:0] cpu_dout_o;
    logic        cpu_valid_o;
    logic        cpu_busy_o;
    logic        mem_rden_o;
    logic [13:0] mem_addr_o;
    logic [31:0] mem_dout_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cpu_rden_i(cpu_rden_i), .cpu_addr_i(cpu_addr_i),
        .flush_i(flush_i), .cpu_dout_o(cpu_dout_o), .cpu_valid_o(cpu_valid_o),
        .cpu_busy_o(cpu_busy_o), .mem_rden_o(mem_rden_o), .mem_addr_o(mem_addr_o),
        .mem_dout_i(mem_dout_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory: data valid one cycle after strobe, word n holds n.
    always @(posedge clk_i) begin
        if (mem_rden_o) mem_dout_i <= {18'b0, mem_addr_o};
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full miss: request, WORDS strobes, response, return to idle.
    task automatic miss_seq(input logic [31:0] addr, input logic [31:0] exp_dout,
                            input logic [15:0] exp_miss, input int flush_at, input bit hold);
        logic [31:0] base;
        base       = (addr >> 2) & 32'h0000_3FFC;
        cpu_rden_i = 1'b1;
        cpu_addr_i = addr;
        step();
        flush_i    = 1'b0;
        cpu_rden_i = hold;
        chk("miss_cnt", {16'b0, miss_cnt_o}, {16'b0, exp_miss});
        for (int k = 0; k < 4; k++) begin
            chk("fill_rden", {31'b0, mem_rden_o}, 32'd1);
            chk("fill_addr", {18'b0, mem_addr_o}, base + k);
            chk("fill_busy", {31'b0, cpu_busy_o}, 32'd1);
            chk("fill_valid", {31'b0, cpu_valid_o}, 32'd0);
            flush_i = (k == flush_at);
            step();
            flush_i = 1'b0;
        end
        chk("last_rden", {31'b0, mem_rden_o}, 32'd0);
        chk("addr_hold", {18'b0, mem_addr_o}, base + 3);
        chk("last_valid", {31'b0, cpu_valid_o}, 32'd0);
        step();
        cpu_rden_i = 1'b0;
        chk("resp_valid", {31'b0, cpu_valid_o}, 32'd1);
        chk("resp_dout", cpu_dout_o, exp_dout);
        chk("resp_busy", {31'b0, cpu_busy_o}, 32'd1);
        chk("resp_rden", {31'b0, mem_rden_o}, 32'd0);
        chk("resp_miss", {16'b0, miss_cnt_o}, {16'b0, exp_miss});
        step();
        chk("post_valid", {31'b0, cpu_valid_o}, 32'd0);
        chk("post_busy", {31'b0, cpu_busy_o}, 32'd0);
    endtask

    task automatic hit_step(input logic [31:0] addr, input logic [31:0] exp_dout,
                            input logic [15:0] exp_hit);
        cpu_rden_i = 1'b1;
        cpu_addr_i = addr;
        step();
        chk("hit_valid", {31'b0, cpu_valid_o}, 32'd1);
        chk("hit_dout", cpu_dout_o, exp_dout);
        chk("hit_busy", {31'b0, cpu_busy_o}, 32'd0);
        chk("hit_rden", {31'b0, mem_rden_o}, 32'd0);
        chk("hit_cnt", {16'b0, hit_cnt_o}, {16'b0, exp_hit});
    endtask

    initial begin
        rst_ni     = 1'b0;
        cpu_rden_i = 1'b0;
        cpu_addr_i = 32'h0;
        flush_i    = 1'b0;
        mem_dout_i = 32'h0;
        step();
        step();
        // Reset state
        chk("rst_valid", {31'b0, cpu_valid_o}, 32'd0);
        chk("rst_busy", {31'b0, cpu_busy_o}, 32'd0);
        chk("rst_rden", {31'b0, mem_rden_o}, 32'd0);
        chk("rst_addr", {18'b0, mem_addr_o}, 32'd0);
        chk("rst_dout", cpu_dout_o, 32'd0);
        chk("rst_hit", {16'b0, hit_cnt_o}, 32'd0);
        chk("rst_miss", {16'b0, miss_cnt_o}, 32'd0);
        rst_ni = 1'b1;

        // Cold miss on 0x100
        miss_seq(32'h100, 32'h40, 16'd1, -1, 1'b0);
        // Hit streak, back to back
        hit_step(32'h104, 32'h41, 16'd1);
        hit_step(32'h108, 32'h42, 16'd2);
        hit_step(32'h10C, 32'h43, 16'd3);
        cpu_rden_i = 1'b0;
        step();
        chk("streak_end_valid", {31'b0, cpu_valid_o}, 32'd0);
        chk("streak_miss", {16'b0, miss_cnt_o}, 32'd1);

        // Conflict on index 0, then original line misses again
        miss_seq(32'h1100, 32'h440, 16'd2, -1, 1'b0);
        miss_seq(32'h100, 32'h40, 16'd3, -1, 1'b0);

        // Flush during fill: data delivered, line left invalid
        miss_seq(32'h200, 32'h80, 16'd4, 1, 1'b0);
        miss_seq(32'h208, 32'h82, 16'd5, -1, 1'b0);
        hit_step(32'h20C, 32'h83, 16'd4);
        cpu_rden_i = 1'b0;
        // Flush in idle with same-cycle request counts as a miss
        flush_i = 1'b1;
        miss_seq(32'h204, 32'h81, 16'd6, -1, 1'b0);
        chk("flush_idle_hit", {16'b0, hit_cnt_o}, 32'd4);

        // Reset in FILL cycle 2
        cpu_rden_i = 1'b1;
        cpu_addr_i = 32'h300;
        step();
        cpu_rden_i = 1'b0;
        step();
        step();
        chk("pre_rst_rden", {31'b0, mem_rden_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_rden", {31'b0, mem_rden_o}, 32'd0);
        chk("mid_rst_busy", {31'b0, cpu_busy_o}, 32'd0);
        chk("mid_rst_hit", {16'b0, hit_cnt_o}, 32'd0);
        chk("mid_rst_miss", {16'b0, miss_cnt_o}, 32'd0);
        step();
        chk("mid_rst_valid", {31'b0, cpu_valid_o}, 32'd0);
        rst_ni = 1'b1;
        miss_seq(32'h100, 32'h40, 16'd1, -1, 1'b0);

        // Request held high through the fill counts once
        miss_seq(32'h400, 32'h100, 16'd2, -1, 1'b1);
        chk("gated_hit", {16'b0, hit_cnt_o}, 32'd0);

        // Saturation of the hit counter
        cpu_rden_i = 1'b1;
        cpu_addr_i = 32'h404;
        repeat (65534) step();
        chk("sat_fffe", {16'b0, hit_cnt_o}, 32'h0000FFFE);
        step();
        chk("sat_ffff", {16'b0, hit_cnt_o}, 32'h0000FFFF);
        step();
        chk("sat_hold", {16'b0, hit_cnt_o}, 32'h0000FFFF);
        chk("sat_dout", cpu_dout_o, 32'h101);
        chk("sat_miss", {16'b0, miss_cnt_o}, 32'd2);
        cpu_rden_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
